// File: rtl/fantasticfft_fftn.sv
// rtl/fantasticfft_fftn.sv - N-point radix-2 DIT FFT, one time-shared butterfly, streaming load/unload
module fantasticfft_fftn #(
    parameter int INT_SIZE  = 8,
    parameter int FRAC_SIZE = 8,
    parameter int LOG2_N    = 3,
    parameter int SCALE     = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [INT_SIZE+FRAC_SIZE-1:0] in_real,
    input  logic signed [INT_SIZE+FRAC_SIZE-1:0] in_imag,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [INT_SIZE+FRAC_SIZE-1:0] out_real,
    output logic signed [INT_SIZE+FRAC_SIZE-1:0] out_imag,
    output logic [LOG2_N-1:0]                   out_index,
    output logic                                out_last,
    output logic                                busy
);
    localparam int W    = INT_SIZE + FRAC_SIZE;
    localparam int N    = 1 << LOG2_N;
    localparam int TW_W = FRAC_SIZE + 2;
    localparam int PW   = W + TW_W + 2;
    localparam int SW   = $clog2(LOG2_N);
    localparam real PI  = 3.14159265358979323846;
    localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (W - 1) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (W - 1)));

    typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

    function automatic int round_q(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] v);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) r[i] = v[LOG2_N-1-i];
        return r;
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [PW-1:0] x);
        if (x > SAT_MAX)      return {1'b0, {(W-1){1'b1}}};
        else if (x < SAT_MIN) return {1'b1, {(W-1){1'b0}}};
        else                  return x[W-1:0];
    endfunction

    logic signed [TW_W-1:0] tw_re [N/2];
    logic signed [TW_W-1:0] tw_im [N/2];

    for (genvar k = 0; k < N/2; k++) begin : g_tw
        localparam real ANG   = 2.0 * PI * k / N;
        localparam int  COS_Q = round_q($cos(ANG) * (2.0 ** FRAC_SIZE));
        localparam int  SIN_Q = round_q($sin(ANG) * (2.0 ** FRAC_SIZE));
        assign tw_re[k] = TW_W'(COS_Q);
        assign tw_im[k] = TW_W'(-SIN_Q);
    end

    logic signed [W-1:0] mem_re [N];
    logic signed [W-1:0] mem_im [N];

    state_t              state;
    logic [LOG2_N-1:0]   load_cnt;
    logic [SW-1:0]       stg;
    logic [LOG2_N-2:0]   bfly;
    logic                ld_fire;

    // Butterfly addressing: the bit at position stg is inserted as 0 (top) or 1 (bottom).
    logic [LOG2_N-1:0]   half, pos, top_idx, bot_idx;
    logic [LOG2_N-2:0]   tw_idx;

    assign half    = LOG2_N'(1) << stg;
    assign pos     = {1'b0, bfly} & (half - LOG2_N'(1));
    assign top_idx = (({1'b0, bfly} & ~(half - LOG2_N'(1))) << 1) | pos;
    assign bot_idx = top_idx | half;
    assign tw_idx  = (LOG2_N-1)'(pos << (SW'(LOG2_N - 1) - stg));
    assign ld_fire = (state == ST_LOAD) && in_valid && in_ready;

    logic signed [PW-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic signed [PW-1:0] p_re, p_im, s_re, s_im, d_re, d_im;

    always_comb begin
        a_re = PW'(mem_re[top_idx]);
        a_im = PW'(mem_im[top_idx]);
        b_re = PW'(mem_re[bot_idx]);
        b_im = PW'(mem_im[bot_idx]);
        w_re = PW'(tw_re[tw_idx]);
        w_im = PW'(tw_im[tw_idx]);
        p_re = (b_re * w_re - b_im * w_im) >>> FRAC_SIZE;
        p_im = (b_re * w_im + b_im * w_re) >>> FRAC_SIZE;
        s_re = a_re + p_re;
        s_im = a_im + p_im;
        d_re = a_re - p_re;
        d_im = a_im - p_im;
        if (SCALE != 0) begin
            s_re = s_re >>> 1;
            s_im = s_im >>> 1;
            d_re = d_re >>> 1;
            d_im = d_im >>> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem_re[bitrev(load_cnt)] <= in_real;
            mem_im[bitrev(load_cnt)] <= in_imag;
        end else if (state == ST_COMPUTE) begin
            mem_re[top_idx] <= sat(s_re);
            mem_im[top_idx] <= sat(s_im);
            mem_re[bot_idx] <= sat(d_re);
            mem_im[bot_idx] <= sat(d_im);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            load_cnt  <= '0;
            stg       <= '0;
            bfly      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    in_ready <= 1'b1;
                    if (ld_fire) begin
                        load_cnt <= load_cnt + LOG2_N'(1);
                        if (load_cnt == LOG2_N'(N - 1)) begin
                            state    <= ST_COMPUTE;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    bfly <= bfly + (LOG2_N-1)'(1);
                    if (bfly == '1) begin
                        stg <= stg + SW'(1);
                        if (stg == SW'(LOG2_N - 1)) begin
                            state     <= ST_UNLOAD;
                            stg       <= '0;
                            out_valid <= 1'b1;
                            out_index <= '0;
                            out_last  <= 1'b0;
                        end
                    end
                end
                ST_UNLOAD: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= ST_LOAD;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_index <= '0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            out_index <= out_index + LOG2_N'(1);
                            out_last  <= (out_index == LOG2_N'(N - 2));
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // The file is untouched during UNLOAD, so the presented bin holds while stalled.
    assign out_real = out_valid ? mem_re[out_index] : '0;
    assign out_imag = out_valid ? mem_im[out_index] : '0;

endmodule
